// File: rtl/fetch_stage.sv
// Instruction fetch stage: sequential single-outstanding fetch into a small FIFO,
// feeding instruction/PC to decode with stall, flush-redirect and NOP injection.
module fetch_stage #(
   parameter int               width       = 32,
   parameter logic [width-1:0] resetVector = '0,
   parameter int               bufDepth    = 2
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             stall,
   input  logic             flush,
   input  logic [width-1:0] flushAddr,
   output logic             memReq,
   output logic [width-1:0] memAddr,
   input  logic             memAck,
   input  logic [width-1:0] memData,
   output logic [width-1:0] instruction,
   output logic [width-1:0] PC
);

   localparam int PW = $clog2(bufDepth);
   localparam int CW = PW + 1;
   localparam logic [width-1:0] NOP = width'(32'h0000_0013);

   logic [width-1:0] fetchPC;
   logic             outstanding, discard;
   logic [width-1:0] bufAddr [bufDepth];
   logic [width-1:0] bufWord [bufDepth];
   logic [PW-1:0]    rdPtr, wrPtr;
   logic [CW-1:0]    count;

   logic full, issue, ack, push, pop;

   always_comb begin
      full  = (count == CW'(bufDepth));
      issue = !outstanding && !full && !flush;
      ack   = memAck && outstanding;
      // memAddr still names the outstanding request, so it tags the returned word
      push  = ack && !discard && !flush;
      pop   = !stall && !flush && (count != '0);
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         fetchPC     <= resetVector;
         outstanding <= 1'b0;
         discard     <= 1'b0;
         rdPtr       <= '0;
         wrPtr       <= '0;
         count       <= '0;
         memReq      <= 1'b0;
         memAddr     <= resetVector;
         instruction <= NOP;
         PC          <= resetVector;
      end else begin
         memReq <= issue;
         if (issue) begin
            memAddr <= fetchPC;
            fetchPC <= fetchPC + width'(4);
         end
         if (flush)
            fetchPC <= flushAddr;

         if (issue)
            outstanding <= 1'b1;
         else if (ack)
            outstanding <= 1'b0;

         if (ack)
            discard <= 1'b0;
         else if (flush && outstanding)
            discard <= 1'b1;

         if (flush) begin
            rdPtr       <= '0;
            wrPtr       <= '0;
            count       <= '0;
            instruction <= NOP;
         end else begin
            if (pop) begin
               instruction <= bufWord[rdPtr];
               PC          <= bufAddr[rdPtr];
               rdPtr       <= rdPtr + PW'(1);
            end else if (!stall) begin
               instruction <= NOP;
            end
            // pop reads the old head, so a push into an empty FIFO is never bypassed
            if (push) begin
               bufWord[wrPtr] <= memData;
               bufAddr[wrPtr] <= memAddr;
               wrPtr          <= wrPtr + PW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
         end
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized bench for fetch_stage: a queue-based reference model of the fetch
// rules is compared against the DUT every cycle, plus a few directed spot checks.
module tb_fetch_stage;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rstn = 1'b0, stall = 1'b0, flush = 1'b0, memAck = 1'b0;
   logic [31:0] flushAddr = '0, memData = '0;
   logic        memReq;
   logic [31:0] memAddr, instruction, PC;

   logic        w_ack = 1'b0, w_req;
   logic [31:0] w_data = '0, w_addr, w_instr, w_pc;

   fetch_stage u_dut (
      .clk(clk), .rstn(rstn), .stall(stall), .flush(flush), .flushAddr(flushAddr),
      .memReq(memReq), .memAddr(memAddr), .memAck(memAck), .memData(memData),
      .instruction(instruction), .PC(PC)
   );

   fetch_stage #(.resetVector(32'hFFFF_FFFC)) u_wrap (
      .clk(clk), .rstn(rstn), .stall(1'b0), .flush(1'b0), .flushAddr(32'h0),
      .memReq(w_req), .memAddr(w_addr), .memAck(w_ack), .memData(w_data),
      .instruction(w_instr), .PC(w_pc)
   );

   int n_tests = 0, n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // reference model: FIFO as a queue, state updated from the rules directly
   typedef struct { logic [31:0] a; logic [31:0] w; } ent_t;
   ent_t        q[$];
   logic [31:0] m_fpc = '0, m_addr = '0, m_instr = NOP, m_pc = '0;
   bit          m_out = 0, m_disc = 0, m_req = 0;

   task automatic model_step();
      bit iss, ak;
      if (!rstn) begin
         q.delete();
         m_fpc = '0; m_out = 0; m_disc = 0; m_req = 0;
         m_addr = '0; m_instr = NOP; m_pc = '0;
         return;
      end
      iss = !m_out && q.size() < 2 && !flush;
      ak  = memAck && m_out;
      if (flush) begin
         q.delete();
         m_instr = NOP;
      end else begin
         if (!stall) begin
            if (q.size() > 0) begin
               ent_t e;
               e = q.pop_front();
               m_instr = e.w;
               m_pc    = e.a;
            end else m_instr = NOP;
         end
         if (ak && !m_disc) q.push_back(ent_t'{m_addr, memData});
      end
      if (ak) m_disc = 0;
      else if (flush && m_out) m_disc = 1;
      if (iss) m_out = 1;
      else if (ak) m_out = 0;
      m_req = iss;
      if (iss) begin
         m_addr = m_fpc;
         m_fpc  = m_fpc + 32'd4;
      end
      if (flush) m_fpc = flushAddr;
   endtask

   // memory: each request gets an ack after minlat..maxlat edges, data = addr + 0x100
   typedef struct { int due; logic [31:0] a; } pend_t;
   pend_t       pend[$];
   int          minlat = 1, maxlat = 1, cyc_n = 0;
   logic [31:0] wrap_a[$];
   bit          w_seen = 0;
   logic [31:0] w_first_i = '0, w_first_pc = '0;

   task automatic cyc(input bit s, input bit f, input bit r, input logic [31:0] fa);
      stall = s; flush = f; rstn = r; flushAddr = fa;
      @(posedge clk);
      model_step();
      #1;
      cyc_n++;
      chk("memReq", 32'(memReq), 32'(m_req));
      chk("memAddr", memAddr, m_addr);
      chk("instruction", instruction, m_instr);
      chk("PC", PC, m_pc);
      if (memReq)
         pend.push_back(pend_t'{cyc_n + int'($urandom_range(maxlat, minlat)) - 1, memAddr});
      memAck = 1'b0;
      for (int i = 0; i < pend.size(); i++) begin
         if (pend[i].due <= cyc_n) begin
            if (!memAck) begin
               memAck  = 1'b1;
               memData = pend[i].a + 32'h100;
            end
            pend.delete(i);
            i--;
         end
      end
      if (cyc_n < 30) begin
         if (w_req) wrap_a.push_back(w_addr);
         if (!w_seen && w_instr != NOP) begin
            w_seen = 1; w_first_i = w_instr; w_first_pc = w_pc;
         end
      end
      w_ack  = w_req;
      w_data = w_addr + 32'h100;
   endtask

   initial begin
      int k;
      bit got_ack;
      cyc(0, 0, 0, 0);
      cyc(0, 0, 0, 0);
      chk("rst_instr", instruction, NOP);
      chk("rst_pc", PC, 32'h0);
      chk("rst_req", 32'(memReq), 32'h0);

      // L=1 streaming
      for (int i = 0; i < 20; i++) cyc(0, 0, 1, 0);

      // stall held 6 cycles, then release
      for (int i = 0; i < 6; i++) cyc(1, 0, 1, 0);
      for (int i = 0; i < 8; i++) cyc(0, 0, 1, 0);

      if (wrap_a.size() < 2) chk("wrap_cnt", 32'(wrap_a.size()), 32'd2);
      else begin
         chk("wrap_a0", wrap_a[0], 32'hFFFF_FFFC);
         chk("wrap_a1", wrap_a[1], 32'h0000_0000);
      end
      chk("wrap_i0", w_first_i, 32'h0000_00FC);
      chk("wrap_pc0", w_first_pc, 32'hFFFF_FFFC);

      // L=4, flush to 0x200 while a request is outstanding
      minlat = 4; maxlat = 4;
      for (int i = 0; i < 7; i++) cyc(0, 0, 1, 0);
      cyc(0, 1, 1, 32'h200);
      for (int i = 0; i < 14; i++) cyc(0, 0, 1, 0);

      // flush coincident with memAck and stall
      minlat = 2; maxlat = 2;
      got_ack = 0;
      for (k = 0; k < 20 && !got_ack; k++) begin
         if (memAck) got_ack = 1;
         else cyc(0, 0, 1, 0);
      end
      if (!got_ack) chk("ack_wait", 32'h0, 32'h1);
      else begin
         cyc(1, 1, 1, 32'h300);
         chk("fl_ack_nop", instruction, NOP);
         cyc(0, 0, 1, 0);
         chk("fl_ack_req", 32'(memReq), 32'h1);
         chk("fl_ack_addr", memAddr, 32'h300);
      end
      for (int i = 0; i < 6; i++) cyc(0, 0, 1, 0);

      // one-cycle reset with buffered words and in-flight requests
      minlat = 3; maxlat = 3;
      for (int i = 0; i < 10; i++) cyc(1, 0, 1, 0);
      cyc(0, 0, 1, 0);
      cyc(0, 0, 1, 0);
      cyc(0, 0, 0, 0);
      chk("mid_rst_instr", instruction, NOP);
      chk("mid_rst_pc", PC, 32'h0);
      for (int i = 0; i < 12; i++) cyc(0, 0, 1, 0);

      // random mix of latency, stall, flush and occasional reset
      minlat = 1; maxlat = 4;
      for (int i = 0; i < 400; i++)
         cyc(($urandom % 100) < 30, ($urandom % 100) < 6, ($urandom % 100) >= 1,
             ($urandom % 256) << 2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
